// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage definitions: register/address types, stage structs and FSM states.
package wb_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [XLEN-1:0]   Register;
  typedef logic [REG_AW-1:0] RegAddr;

  typedef enum logic {
    IDLE,
    WAIT_LD
  } WbState;

  typedef struct packed {
    logic    valid;
    RegAddr  dst;
    Register result;
    logic    is_load;
  } WB_input;

  typedef struct packed {
    logic    write;
    RegAddr  dst;
    Register data;
  } WB_output;

endpackage

// File: rtl/wb_stage_load_timer.sv
// Load-wait cycle counter; pulses tmo on the tick that brings the count to LOAD_TMO.
module wb_load_timer #(
  parameter int unsigned LOAD_TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic tmo
);

  localparam int unsigned CW = $clog2(LOAD_TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(LOAD_TMO);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    tmo     = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != TMO_C)) begin
      // Saturates at LOAD_TMO so the count can never wrap back into range.
      cnt_d = cnt_inc;
      tmo   = (cnt_inc == TMO_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: retires ALU results and outstanding loads onto the register-file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_TMO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_dst,
  input  logic [DATA_W-1:0] m_result,
  input  logic              m_is_load,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_write,
  output logic [ADDR_W-1:0] wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_dst,
  output logic              err_tmo
);

  WbState state_q, state_d;
  logic              wb_write_q, wb_write_d;
  logic [ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_dst_q, pend_dst_d;
  logic              err_tmo_q, err_tmo_d;
  logic              tmo;

  wb_load_timer #(
    .LOAD_TMO(LOAD_TMO)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == IDLE),
    .tick ((state_q == WAIT_LD) && !mem_rvalid),
    .tmo  (tmo)
  );

  always_comb begin
    state_d      = state_q;
    wb_write_d   = 1'b0;
    wb_dst_d     = wb_dst_q;
    wb_data_d    = wb_data_q;
    pend_valid_d = pend_valid_q;
    pend_dst_d   = pend_dst_q;
    err_tmo_d    = err_tmo_q;
    m_ready      = (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          if (m_is_load) begin
            pend_dst_d   = m_dst;
            pend_valid_d = 1'b1;
            state_d      = WAIT_LD;
          end else begin
            wb_write_d = (m_dst != '0);
            wb_dst_d   = m_dst;
            wb_data_d  = m_result;
          end
        end
      end
      WAIT_LD: begin
        if (mem_rvalid) begin
          wb_write_d   = (pend_dst_q != '0);
          wb_dst_d     = pend_dst_q;
          wb_data_d    = mem_rdata;
          pend_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (tmo) begin
          err_tmo_d    = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wb_write_q   <= 1'b0;
      wb_dst_q     <= '0;
      wb_data_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_dst_q   <= '0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_write_q   <= wb_write_d;
      wb_dst_q     <= wb_dst_d;
      wb_data_q    <= wb_data_d;
      pend_valid_q <= pend_valid_d;
      pend_dst_q   <= pend_dst_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign wb_write   = wb_write_q;
  assign wb_dst     = wb_dst_q;
  assign wb_data    = wb_data_q;
  assign pend_valid = pend_valid_q;
  assign pend_dst   = pend_dst_q;
  assign err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU writes, r0 suppression, loads, ordering, timeout and mid-load reset.
module tb_wb_stage;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned LOAD_TMO = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_dst;
  logic [DATA_W-1:0] m_result;
  logic              m_is_load;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_dst;
  logic              err_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LOAD_TMO(LOAD_TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_dst     (m_dst),
    .m_result  (m_result),
    .m_is_load (m_is_load),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .wb_write  (wb_write),
    .wb_dst    (wb_dst),
    .wb_data   (wb_data),
    .pend_valid(pend_valid),
    .pend_dst  (pend_dst),
    .err_tmo   (err_tmo)
  );

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_valid = 1'b0; m_dst = '0; m_result = '0; m_is_load = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL reset_wb_write got %b exp 0", wb_write); end
    n_checks++; if (wb_dst !== 5'd0) begin n_fail++; $display("FAIL reset_wb_dst got %0d exp 0", wb_dst); end
    n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    n_checks++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend_valid got %b exp 0", pend_valid); end
    n_checks++; if (pend_dst !== 5'd0) begin n_fail++; $display("FAIL reset_pend_dst got %0d exp 0", pend_dst); end
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_err_tmo got %b exp 0", err_tmo); end
    reset = 1'b0;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_m_ready got %b exp 1", m_ready); end
  endtask

  task automatic test_alu();
    m_valid = 1'b1; m_is_load = 1'b0; m_dst = 5'd5; m_result = 32'hDEADBEEF;
    step();
    m_valid = 1'b0;
    n_checks++; if (wb_write !== 1'b1) begin n_fail++; $display("FAIL alu_wb_write got %b exp 1", wb_write); end
    n_checks++; if (wb_dst !== 5'd5) begin n_fail++; $display("FAIL alu_wb_dst got %0d exp 5", wb_dst); end
    n_checks++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wb_data got %h exp deadbeef", wb_data); end
    step();
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL alu_pulse_end got %b exp 0", wb_write); end
    n_checks++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data_hold got %h exp deadbeef", wb_data); end
  endtask

  task automatic test_r0();
    m_valid = 1'b1; m_is_load = 1'b0; m_dst = 5'd0; m_result = 32'h1234;
    step();
    m_valid = 1'b0;
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL r0_wb_write got %b exp 0", wb_write); end
    n_checks++; if (wb_dst !== 5'd0) begin n_fail++; $display("FAIL r0_wb_dst got %0d exp 0", wb_dst); end
    n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL r0_wb_data got %h exp 1234", wb_data); end
  endtask

  task automatic test_load();
    m_valid = 1'b1; m_is_load = 1'b1; m_dst = 5'd8; m_result = 32'hFFFF_FFFF;
    step();
    m_valid = 1'b0; m_is_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL ld_pend_valid[%0d] got %b exp 1", i, pend_valid); end
      n_checks++; if (pend_dst !== 5'd8) begin n_fail++; $display("FAIL ld_pend_dst[%0d] got %0d exp 8", i, pend_dst); end
      n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL ld_m_ready[%0d] got %b exp 0", i, m_ready); end
      n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL ld_wait_write[%0d] got %b exp 0", i, wb_write); end
      if (i == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'h42; end
      step();
    end
    mem_rvalid = 1'b0;
    n_checks++; if (wb_write !== 1'b1) begin n_fail++; $display("FAIL ld_wb_write got %b exp 1", wb_write); end
    n_checks++; if (wb_dst !== 5'd8) begin n_fail++; $display("FAIL ld_wb_dst got %0d exp 8", wb_dst); end
    n_checks++; if (wb_data !== 32'h42) begin n_fail++; $display("FAIL ld_wb_data got %h exp 42", wb_data); end
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL ld_done_m_ready got %b exp 1", m_ready); end
    n_checks++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL ld_done_pend got %b exp 0", pend_valid); end
    step();
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL ld_pulse_end got %b exp 0", wb_write); end
  endtask

  task automatic test_back_to_back();
    m_valid = 1'b1; m_is_load = 1'b1; m_dst = 5'd3;
    step();
    // ALU op presented immediately and held until accepted
    m_is_load = 1'b0; m_dst = 5'd4; m_result = 32'hABCD;
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall0 got %b exp 0", m_ready); end
    step();
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL b2b_early_write got %b exp 0", wb_write); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1 got %b exp 0", m_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'h7;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (wb_write !== 1'b1) begin n_fail++; $display("FAIL b2b_ld_write got %b exp 1", wb_write); end
    n_checks++; if (wb_dst !== 5'd3) begin n_fail++; $display("FAIL b2b_ld_dst got %0d exp 3", wb_dst); end
    n_checks++; if (wb_data !== 32'h7) begin n_fail++; $display("FAIL b2b_ld_data got %h exp 7", wb_data); end
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b exp 1", m_ready); end
    step();
    m_valid = 1'b0;
    n_checks++; if (wb_write !== 1'b1) begin n_fail++; $display("FAIL b2b_alu_write got %b exp 1", wb_write); end
    n_checks++; if (wb_dst !== 5'd4) begin n_fail++; $display("FAIL b2b_alu_dst got %0d exp 4", wb_dst); end
    n_checks++; if (wb_data !== 32'hABCD) begin n_fail++; $display("FAIL b2b_alu_data got %h exp abcd", wb_data); end
    step();
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", wb_write); end
  endtask

  task automatic test_timeout();
    m_valid = 1'b1; m_is_load = 1'b1; m_dst = 5'd9;
    step();
    m_valid = 1'b0; m_is_load = 1'b0;
    for (int i = 1; i <= int'(LOAD_TMO); i++) begin
      step();
      if (i < int'(LOAD_TMO)) begin
        n_checks++; if (err_tmo !== 1'b0 || m_ready !== 1'b0) begin
          n_fail++; $display("FAIL tmo_early[%0d] got err=%b rdy=%b exp err=0 rdy=0", i, err_tmo, m_ready);
        end
      end
    end
    n_checks++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b exp 1", err_tmo); end
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL tmo_write got %b exp 0", wb_write); end
    n_checks++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_pend got %b exp 0", pend_valid); end
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready got %b exp 1", m_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (wb_write !== 1'b0) begin n_fail++; $display("FAIL late_rvalid_write got %b exp 0", wb_write); end
    n_checks++; if (wb_data !== 32'hABCD) begin n_fail++; $display("FAIL late_rvalid_data got %h exp abcd", wb_data); end
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL late_rvalid_ready got %b exp 1", m_ready); end
    m_valid = 1'b1; m_dst = 5'd6; m_result = 32'h55;
    step();
    m_valid = 1'b0;
    n_checks++; if (wb_write !== 1'b1 || wb_dst !== 5'd6 || wb_data !== 32'h55) begin
      n_fail++; $display("FAIL tmo_next_op got w=%b d=%0d v=%h exp w=1 d=6 v=55", wb_write, wb_dst, wb_data);
    end
    n_checks++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b exp 1", err_tmo); end
  endtask

  task automatic test_reset_mid_load();
    m_valid = 1'b1; m_is_load = 1'b1; m_dst = 5'd10;
    step();
    m_valid = 1'b0; m_is_load = 1'b0;
    n_checks++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL rml_pend got %b exp 1", pend_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (wb_write !== 1'b0 || wb_dst !== 5'd0 || wb_data !== 32'h0) begin
      n_fail++; $display("FAIL rml_wb got w=%b d=%0d v=%h exp 0/0/0", wb_write, wb_dst, wb_data);
    end
    n_checks++; if (pend_valid !== 1'b0 || pend_dst !== 5'd0) begin
      n_fail++; $display("FAIL rml_pend_clr got v=%b d=%0d exp 0/0", pend_valid, pend_dst);
    end
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL rml_err got %b exp 0", err_tmo); end
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rml_ready got %b exp 1", m_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    step();
    mem_rvalid = 1'b0;
    n_checks++; if (wb_write !== 1'b0 || wb_data !== 32'h0) begin
      n_fail++; $display("FAIL rml_stale_rvalid got w=%b v=%h exp 0/0", wb_write, wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_r0();
    test_load();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
